vga_pattern_gen: RTL



---
 rtl/vga_pkg.sv | 43 ++++
 rtl/vga_pattern_gen_box_mover.sv | 57 +++++
 rtl/vga_pattern_gen.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared colours, pattern modes and pipeline types for the VGA pattern generator
package vga_pkg;

    localparam logic [11:0] BLACK   = 12'h000;
    localparam logic [11:0] RED     = 12'hF00;
    localparam logic [11:0] GREEN   = 12'h0F0;
    localparam logic [11:0] BLUE    = 12'h00F;
    localparam logic [11:0] WHITE   = 12'hFFF;
    localparam logic [11:0] YELLOW  = 12'hFF0;
    localparam logic [11:0] CYAN    = 12'h0FF;
    localparam logic [11:0] MAGENTA = 12'hF0F;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_BOX   = 2'd3
    } mode_t;

    // Classic colour-bar order, brightest first; index wraps every 8 bars
    function automatic logic [11:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_color = WHITE;
            3'd1:    bar_color = YELLOW;
            3'd2:    bar_color = CYAN;
            3'd3:    bar_color = GREEN;
            3'd4:    bar_color = MAGENTA;
            3'd5:    bar_color = RED;
            3'd6:    bar_color = BLUE;
            default: bar_color = BLACK;
        endcase
    endfunction

    // First pipeline stage: active-area flag, pixel coordinates and delayed syncs
    typedef struct packed {
        logic       active;
        logic [9:0] x;
        logic [9:0] y;
        logic       hsync;
        logic       vsync;
    } stage1_t;

endpackage

// File: rtl/vga_pattern_gen_box_mover.sv
// rtl/vga_pattern_gen_box_mover.sv - bouncing square position, advanced once per frame
module vga_box_mover
    import vga_pkg::*;
#(
    parameter int BOX_SIZE = 32,
    parameter int BOX_STEP = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       tick,
    input  logic [9:0] hlenght,
    input  logic [9:0] vlenght,
    output logic [9:0] bx,
    output logic [9:0] by
);

    // Direction flags: 1 = moving towards larger coordinates
    logic dir_x;
    logic dir_y;
    logic [10:0] next_x;
    logic [10:0] next_y;

    // One axis of the bounce rule; returns {new_dir, new_pos}. Sums at 11 bits so the far-edge compare never wraps.
    function automatic logic [10:0] axis_step(input logic [9:0] pos, input logic dir, input logic [9:0] len);
        logic [10:0] far_edge;
        far_edge = {1'b0, pos} + 11'(BOX_SIZE) + 11'(BOX_STEP);
        if (dir) begin
            if (far_edge > {1'b0, len}) axis_step = {1'b0, pos - 10'(BOX_STEP)};
            else                        axis_step = {1'b1, pos + 10'(BOX_STEP)};
        end else begin
            if (pos < 10'(BOX_STEP))    axis_step = {1'b1, pos + 10'(BOX_STEP)};
            else                        axis_step = {1'b0, pos - 10'(BOX_STEP)};
        end
    endfunction

    // Candidate position/direction for the next tick on both axes
    always_comb begin
        next_x = axis_step(bx, dir_x, hlenght);
        next_y = axis_step(by, dir_y, vlenght);
    end

    // Position only changes on a frame tick so a frame is never torn
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bx    <= '0;
            by    <= '0;
            dir_x <= 1'b1;
            dir_y <= 1'b1;
        end else if (tick) begin
            dir_x <= next_x[10];
            bx    <= next_x[9:0];
            dir_y <= next_y[10];
            by    <= next_y[9:0];
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - two-stage test-pattern pipeline behind the VGA timing counter
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int BOX_SIZE    = 32,
    parameter int BOX_STEP    = 2,
    parameter int BAR_SHIFT   = 6,
    parameter int CHECK_SHIFT = 5
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [9:0]  in_horizontal,
    input  logic [9:0]  in_vertical,
    input  logic        in_hsync,
    input  logic        in_vsync,
    input  logic [9:0]  hstart,
    input  logic [9:0]  hlenght,
    input  logic [9:0]  vstart,
    input  logic [9:0]  vlenght,
    input  logic        mode_btn,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic [11:0] out_color,
    output logic [1:0]  mode
);

    logic    btn_meta;
    logic    btn_sync;
    logic    btn_prev;
    logic    btn_edge;
    logic    vsync_prev;
    logic    frame_tick;
    logic    pending;
    mode_t   mode_q;
    stage1_t s1;
    stage1_t s1_next;
    logic [11:0] color_next;
    logic [9:0]  bx;
    logic [9:0]  by;

    assign mode = mode_q;

    // Two-flop synchroniser for the push-button, plus a delayed copy for edge detection
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            btn_prev <= 1'b0;
        end else begin
            btn_meta <= mode_btn;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
        end
    end

    assign btn_edge   = btn_sync & ~btn_prev;
    assign frame_tick = vsync_prev & ~in_vsync;

    // Previous vsync for the falling-edge frame tick; held high in reset so reset itself is no tick
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) vsync_prev <= 1'b1;
        else        vsync_prev <= in_vsync;
    end

    // Presses are remembered and applied at the next tick; an edge landing on the tick counts for it
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pending <= 1'b0;
            mode_q  <= MODE_SOLID;
        end else if (frame_tick) begin
            if (pending || btn_edge) mode_q <= mode_t'(mode_q + 2'd1);
            pending <= 1'b0;
        end else if (btn_edge) begin
            pending <= 1'b1;
        end
    end

    vga_box_mover #(
        .BOX_SIZE (BOX_SIZE),
        .BOX_STEP (BOX_STEP)
    ) u_box (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .tick    (frame_tick),
        .hlenght (hlenght),
        .vlenght (vlenght),
        .bx      (bx),
        .by      (by)
    );

    // Active-area decode and coordinate offset; 11-bit ends so hstart+hlenght cannot wrap
    always_comb begin
        logic [10:0] h_end;
        logic [10:0] v_end;
        h_end = {1'b0, hstart} + {1'b0, hlenght};
        v_end = {1'b0, vstart} + {1'b0, vlenght};
        s1_next.active = ({1'b0, in_horizontal} >= {1'b0, hstart}) &&
                         ({1'b0, in_horizontal} <  h_end) &&
                         ({1'b0, in_vertical}   >= {1'b0, vstart}) &&
                         ({1'b0, in_vertical}   <  v_end);
        s1_next.x      = in_horizontal - hstart;
        s1_next.y      = in_vertical - vstart;
        s1_next.hsync  = in_hsync;
        s1_next.vsync  = in_vsync;
    end

    // Stage 1 register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) s1 <= '{active: 1'b0, x: 10'd0, y: 10'd0, hsync: 1'b1, vsync: 1'b1};
        else        s1 <= s1_next;
    end

    // Pattern select for the stage-1 pixel; anything outside the active area is black
    always_comb begin
        logic [10:0] x_ext;
        logic [10:0] y_ext;
        logic        in_box;
        x_ext  = {1'b0, s1.x};
        y_ext  = {1'b0, s1.y};
        in_box = (x_ext >= {1'b0, bx}) && (x_ext < {1'b0, bx} + 11'(BOX_SIZE)) &&
                 (y_ext >= {1'b0, by}) && (y_ext < {1'b0, by} + 11'(BOX_SIZE));
        color_next = BLACK;
        if (s1.active) begin
            case (mode_q)
                MODE_SOLID: color_next = RED;
                MODE_BARS:  color_next = bar_color(s1.x[BAR_SHIFT+2 -: 3]);
                MODE_CHECK: color_next = (s1.x[CHECK_SHIFT] ^ s1.y[CHECK_SHIFT]) ? WHITE : BLACK;
                MODE_BOX:   color_next = in_box ? BLUE : BLACK;
                default:    color_next = BLACK;
            endcase
        end
    end

    // Stage 2 register drives the DAC pins directly
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            out_color <= BLACK;
            out_hsync <= 1'b1;
            out_vsync <= 1'b1;
        end else begin
            out_color <= color_next;
            out_hsync <= s1.hsync;
            out_vsync <= s1.vsync;
        end
    end

endmodule
